ita_scroll14: RTL and testbench
===============================

// Module: ita_scroll14
// PURPOSE
// Parametrised 14-segment multiplexed display driver with a writable message buffer and scrolling.
// Scans N_DIGITS common-select lines at a programmable refresh rate.
// Renders a MSG_LEN-character message through an internal glyph ROM.
// Optionally scrolls the message one character left every SCROLL_FRAMES frames.
// Successor to the fixed-text scanners; sits between the user-area logic and the display pads.
// PARAMETERS
// N_DIGITS      12  number of digit select lines; 2..16; must be <= MSG_LEN
// MSG_LEN       16  message buffer depth in characters; 2..64
// REFRESH_DIV   1   clocks per digit slot; >=1 (1 = new digit every clock)
// SCROLL_FRAMES 8   complete frames per scroll step; >=1
// PORTS
// clk         in   1                   system clock, all logic on rising edge
// rst         in   1                   synchronous reset, active high
// msg_we      in   1                   write strobe for message buffer
// msg_addr    in   $clog2(MSG_LEN)     character write address
// msg_char    in   6                   character code written
// scroll_en   in   1                   1 = scrolling active, 0 = hold current offset
// blank       in   1                   1 = force segm to zero (scan continues)
// sel         out  N_DIGITS            one-hot digit select, bit k = digit k (registered)
// segm        out  14                  segment pattern for selected digit (registered)
// frame_done  out  1                   one-clock pulse when digit N_DIGITS-1 -> 0 wrap occurs
// BEHAVIOUR
// Char codes and glyph ROM:
//  - 0 = space (14'b0); 1..26 = A..Z; 27..36 = '0'..'9'; 37..63 = space.
//  - Glyph bit order is the team's standard 14-seg order.
//  - Reference glyphs: A=14'b11101111000000, E=14'b10011110000000, R=14'b11001111000100, S=14'b10110111000000.
// Reset (rst=1 at an edge):
//  - sel=0, segm=0, frame_done=0.
//  - div_cnt=0, dig=N_DIGITS-1, offset=0, frame_cnt=0.
//  - Every buffer entry = 0 (space). Reset overrides every other input, including mid-scan.
// Prescaler:
//  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
//  - tick = (div_cnt==REFRESH_DIV-1). First tick occurs REFRESH_DIV clocks after reset release.
// On a tick edge:
//  - dig_n = (dig==N_DIGITS-1) ? 0 : dig+1; dig <= dig_n.
//  - sel <= 1<<dig_n.
//  - segm <= blank ? 0 : glyph(buf[idx]).
//  - idx = offset_n+dig_n; subtract MSG_LEN once if >= MSG_LEN.
//  - Outputs change on the tick edge itself; they are stable for REFRESH_DIV clocks.
// Frame wrap (tick with dig==N_DIGITS-1):
//  - frame_done=1 for exactly that one clock; otherwise 0.
//  - If scroll_en=1 and frame_cnt==SCROLL_FRAMES-1: frame_cnt<=0 and offset_n=(offset==MSG_LEN-1)?0:offset+1; else frame_cnt<=frame_cnt+1.
//  - The new offset is already used for the digit-0 load on the same edge.
//  - On every other edge, offset_n = offset.
// scroll_en=0:
//  - frame_cnt held at 0 and offset held.
//  - Re-enabling restarts a full SCROLL_FRAMES count.
// Message buffer:
//  - Write on any edge with msg_we=1: buf[msg_addr] <= msg_char. This is independent of tick.
//  - msg_addr >= MSG_LEN: write ignored.
//  - Write and display load of the same entry on the same edge: the display gets the OLD value (read-before-write).
//  - The new character appears on that digit's next scan.
// blank:
//  - Sampled only at tick edges; sel scanning is unaffected.
// All counters wrap and never saturate; there are no illegal states.
// TESTING
// Use N_DIGITS=4, MSG_LEN=8, REFRESH_DIV=4, SCROLL_FRAMES=2 unless stated.
// T1 reset/first scan:
//   Stimulus: rst 2 clocks, release.
//   Required: sel=0, segm=0 for 4 clocks; then sel=4'b0001, segm=0 (space);
//   sel steps 0010, 0100, 1000, 0001 every 4 clocks; frame_done high 1 clock on the 1000->0001 edge.
// T2 message render:
//   Stimulus: write codes 19,5,18,5 ("SERE") to addr 0..3, scroll_en=0.
//   Required: digit 0..3 show S, E, R, E glyphs; pattern repeats every 16 clocks.
// T3 scroll and wrap:
//   Stimulus: T2 contents with addr 4..7 = space, scroll_en=1.
//   Required: offset steps every 2 frames; digit 0 shows E, R, E, space ... then S again after 8 steps (offset wrap 7->0).
// T4 blank and collision:
//   Stimulus: blank=1 for one full frame -> segm=0 on all 4 digits while sel still scans.
//   Stimulus: write 'A'(1) to the addr being loaded on a tick edge -> old glyph shown; A appears next frame.
// T5 bad address / reset mid-frame:
//   Stimulus: msg_we with msg_addr=8 (width 3 wraps; use MSG_LEN=6 and addr 6) -> buffer unchanged.
//   Stimulus: rst asserted mid-frame -> next clock sel=0, segm=0; buffer all spaces.
// T6 REFRESH_DIV=1, N_DIGITS=12, MSG_LEN=12:
//   Required: sel advances every clock; frame_done every 12 clocks.

Source files
------------

// File: rtl/ita_scroll14.sv
`default_nettype none
// ============================================================================
// Module   : ita_scroll14
// Brief    : 14-segment multiplexed display driver, writable message buffer,
//            glyph ROM and frame-based left scrolling.
// Revision : 1.0 - initial release
// ============================================================================
module ita_scroll14 #(
    parameter int N_DIGITS      = 12,
    parameter int MSG_LEN       = 16,
    parameter int REFRESH_DIV   = 1,
    parameter int SCROLL_FRAMES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       msg_we,
    input  logic [$clog2(MSG_LEN)-1:0] msg_addr,
    input  logic [5:0]                 msg_char,
    input  logic                       scroll_en,
    input  logic                       blank,
    output logic [N_DIGITS-1:0]        sel,
    output logic [13:0]                segm,
    output logic                       frame_done
);

    localparam int c_AW = $clog2(MSG_LEN);
    localparam int c_GW = $clog2(N_DIGITS);
    localparam int c_DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [c_DW-1:0]     c_DIV_LAST = c_DW'(REFRESH_DIV - 1);
    localparam logic [c_GW-1:0]     c_DIG_LAST = c_GW'(N_DIGITS - 1);
    localparam logic [c_AW-1:0]     c_OFF_LAST = c_AW'(MSG_LEN - 1);
    localparam logic [c_FW-1:0]     c_FR_LAST  = c_FW'(SCROLL_FRAMES - 1);
    localparam logic [c_AW:0]       c_LEN      = (c_AW + 1)'(MSG_LEN);
    localparam logic [N_DIGITS-1:0] c_SEL_ONE  = N_DIGITS'(1);

    // Bit order {a,b,c,d,e,f,g1,g2,h,j,k,l,m,n}; h..n are the inner segments.
    function automatic logic [13:0] f_glyph(input logic [5:0] code);
        logic [13:0] g;
        case (code)
            6'd1:    g = 14'b11101111_000000; // A
            6'd2:    g = 14'b11110001_010010; // B
            6'd3:    g = 14'b10011100_000000; // C
            6'd4:    g = 14'b11110000_010010; // D
            6'd5:    g = 14'b10011110_000000; // E
            6'd6:    g = 14'b10001110_000000; // F
            6'd7:    g = 14'b10111101_000000; // G
            6'd8:    g = 14'b01101111_000000; // H
            6'd9:    g = 14'b10010000_010010; // I
            6'd10:   g = 14'b01111000_000000; // J
            6'd11:   g = 14'b00001110_001100; // K
            6'd12:   g = 14'b00011100_000000; // L
            6'd13:   g = 14'b01101100_101000; // M
            6'd14:   g = 14'b01101100_100100; // N
            6'd15:   g = 14'b11111100_000000; // O
            6'd16:   g = 14'b11001111_000000; // P
            6'd17:   g = 14'b11111100_000100; // Q
            6'd18:   g = 14'b11001111_000100; // R
            6'd19:   g = 14'b10110111_000000; // S
            6'd20:   g = 14'b10000000_010010; // T
            6'd21:   g = 14'b01111100_000000; // U
            6'd22:   g = 14'b00001100_001001; // V
            6'd23:   g = 14'b01101100_000101; // W
            6'd24:   g = 14'b00000000_101101; // X
            6'd25:   g = 14'b00000000_101010; // Y
            6'd26:   g = 14'b10010000_001001; // Z
            6'd27:   g = 14'b11111100_001001; // 0
            6'd28:   g = 14'b01100000_001000; // 1
            6'd29:   g = 14'b11011011_000000; // 2
            6'd30:   g = 14'b11110001_000000; // 3
            6'd31:   g = 14'b01100111_000000; // 4
            6'd32:   g = 14'b10110111_000000; // 5
            6'd33:   g = 14'b10111111_000000; // 6
            6'd34:   g = 14'b11100000_000000; // 7
            6'd35:   g = 14'b11111111_000000; // 8
            6'd36:   g = 14'b11110111_000000; // 9
            default: g = 14'b0;               // space and unused codes
        endcase
        return g;
    endfunction

    logic [c_DW-1:0]     r_div;
    logic [c_GW-1:0]     r_dig;
    logic [c_AW-1:0]     r_off;
    logic [c_FW-1:0]     r_frame;
    logic [5:0]          r_buf [MSG_LEN];
    logic [N_DIGITS-1:0] r_sel;
    logic [13:0]         r_segm;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_wrap;
    logic                w_step;
    logic [c_GW-1:0]     w_dig_n;
    logic [c_AW-1:0]     w_off_n;
    logic [c_AW:0]       w_sum;
    logic [c_AW-1:0]     w_idx;
    logic [5:0]          w_char;
    logic                w_addr_ok;

    always_comb begin
        w_tick    = (r_div == c_DIV_LAST);
        w_wrap    = w_tick && (r_dig == c_DIG_LAST);
        w_step    = w_wrap && scroll_en && (r_frame == c_FR_LAST);
        w_dig_n   = (r_dig == c_DIG_LAST) ? '0 : r_dig + c_GW'(1);
        w_off_n   = r_off;
        if (w_step) begin
            w_off_n = (r_off == c_OFF_LAST) ? '0 : r_off + c_AW'(1);
        end
        // The freshly stepped offset already applies to the digit-0 load.
        w_sum     = (c_AW + 1)'(w_off_n) + (c_AW + 1)'(w_dig_n);
        w_idx     = (w_sum >= c_LEN) ? c_AW'(w_sum - c_LEN) : c_AW'(w_sum);
        w_char    = r_buf[w_idx];
        w_addr_ok = ({1'b0, msg_addr} < c_LEN);
    end

    // The digit counter resets to the last digit, so the first tick is itself
    // a frame wrap that loads digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= '0;
            r_dig        <= c_DIG_LAST;
            r_off        <= '0;
            r_frame      <= '0;
            r_sel        <= '0;
            r_segm       <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_div        <= w_tick ? '0 : r_div + c_DW'(1);
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_dig  <= w_dig_n;
                r_off  <= w_off_n;
                r_sel  <= c_SEL_ONE << w_dig_n;
                r_segm <= blank ? 14'b0 : f_glyph(w_char);
            end
            if (!scroll_en) begin
                r_frame <= '0;
            end else if (w_wrap) begin
                r_frame <= (r_frame == c_FR_LAST) ? '0 : r_frame + c_FW'(1);
            end
            // Non-blocking write: a same-edge display load sees the old entry.
            if (msg_we && w_addr_ok) begin
                r_buf[msg_addr] <= msg_char;
            end
        end
    end

    assign sel        = r_sel;
    assign segm       = r_segm;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ita_scroll14.sv
`default_nettype none
// ============================================================================
// Module   : tb_ita_scroll14
// Brief    : Self-checking bench for ita_scroll14 using expected-value queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ita_scroll14;

    localparam logic [13:0] c_SP = 14'b0;
    localparam logic [13:0] c_A  = 14'b11101111000000;
    localparam logic [13:0] c_E  = 14'b10011110000000;
    localparam logic [13:0] c_R  = 14'b11001111000100;
    localparam logic [13:0] c_S  = 14'b10110111000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: N=4, LEN=8, DIV=4, FRAMES=2
    logic        rst = 1'b1;
    logic        msg_we = 1'b0;
    logic [2:0]  msg_addr = '0;
    logic [5:0]  msg_char = '0;
    logic        scroll_en = 1'b0;
    logic        blank = 1'b0;
    logic [3:0]  sel;
    logic [13:0] segm;
    logic        frame_done;

    // LEN=6 instance for the out-of-range write
    logic        rst6 = 1'b1;
    logic        we6 = 1'b0;
    logic [2:0]  addr6 = '0;
    logic [5:0]  char6 = '0;
    logic [3:0]  sel6;
    logic [13:0] segm6;
    logic        fd6;

    // N=12, LEN=12, DIV=1 instance
    logic        rst12 = 1'b1;
    logic [11:0] sel12;
    logic [13:0] segm12;
    logic        fd12;

    ita_scroll14 #(.N_DIGITS(4), .MSG_LEN(8), .REFRESH_DIV(4), .SCROLL_FRAMES(2)) u_dut (
        .clk(clk), .rst(rst), .msg_we(msg_we), .msg_addr(msg_addr), .msg_char(msg_char),
        .scroll_en(scroll_en), .blank(blank), .sel(sel), .segm(segm), .frame_done(frame_done)
    );

    ita_scroll14 #(.N_DIGITS(4), .MSG_LEN(6), .REFRESH_DIV(4), .SCROLL_FRAMES(2)) u_dut6 (
        .clk(clk), .rst(rst6), .msg_we(we6), .msg_addr(addr6), .msg_char(char6),
        .scroll_en(1'b0), .blank(1'b0), .sel(sel6), .segm(segm6), .frame_done(fd6)
    );

    ita_scroll14 #(.N_DIGITS(12), .MSG_LEN(12), .REFRESH_DIV(1), .SCROLL_FRAMES(2)) u_dut12 (
        .clk(clk), .rst(rst12), .msg_we(1'b0), .msg_addr(4'd0), .msg_char(6'd0),
        .scroll_en(1'b0), .blank(1'b0), .sel(sel12), .segm(segm12), .frame_done(fd12)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic [13:0] segm;
        logic        fd;
    } exp_t;

    typedef struct packed {
        logic [11:0] sel;
        logic [13:0] segm;
        logic        fd;
    } exp2_t;

    exp_t  exp_q[$];
    exp2_t exp2_q[$];
    int    vectors = 0;
    int    errors  = 0;
    int    since_rst = 0;

    // reference model state of the main instance
    int          m_div, m_dig, m_off, m_fc;
    logic [5:0]  m_buf [8];
    logic [3:0]  m_sel;
    logic [13:0] m_segm;
    logic        m_fd;
    logic [5:0]  sere [4] = '{6'd19, 6'd5, 6'd18, 6'd5};

    function automatic logic [13:0] glyph(input logic [5:0] c);
        case (c)
            6'd1:    return c_A;
            6'd5:    return c_E;
            6'd18:   return c_R;
            6'd19:   return c_S;
            default: return c_SP;
        endcase
    endfunction

    task automatic model_edge();
        int  dn, noff, idx;
        bit  tick, wrap;
        if (rst) begin
            m_div = 0; m_dig = 3; m_off = 0; m_fc = 0;
            m_sel = '0; m_segm = '0; m_fd = 1'b0;
            for (int i = 0; i < 8; i++) m_buf[i] = '0;
        end else begin
            tick  = (m_div == 3);
            wrap  = tick && (m_dig == 3);
            m_div = (m_div + 1) % 4;
            m_fd  = wrap;
            noff  = m_off;
            if (wrap && scroll_en && m_fc == 1) noff = (m_off + 1) % 8;
            if (!scroll_en) m_fc = 0;
            else if (wrap) m_fc = (m_fc + 1) % 2;
            if (tick) begin
                dn     = (m_dig + 1) % 4;
                idx    = (noff + dn) % 8;
                m_sel  = 4'(1 << dn);
                m_segm = blank ? c_SP : glyph(m_buf[idx]);
                m_dig  = dn;
                m_off  = noff;
            end
            if (msg_we) m_buf[msg_addr] = msg_char;
        end
    endtask

    // Advance the model and the clock by one edge, queueing the expected outputs.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        since_rst = rst ? 0 : since_rst + 1;
        exp_q.push_back({m_sel, m_segm, m_fd});
    endtask

    task automatic test_reset();
        exp_t e;
        logic [3:0] es;
        logic ef;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front();
            vectors++;
            if (sel !== e.sel || segm !== e.segm || frame_done !== e.fd) begin
                errors++;
                $display("FAIL reset_hold: sel=%b segm=%b fd=%b, expected sel=%b segm=%b fd=%b",
                         sel, segm, frame_done, e.sel, e.segm, e.fd);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            e = exp_q.pop_front();
            vectors++;
            if (sel !== e.sel || segm !== e.segm || frame_done !== e.fd) begin
                errors++;
                $display("FAIL first_scan c=%0d: sel=%b segm=%b fd=%b, expected sel=%b segm=%b fd=%b",
                         i, sel, segm, frame_done, e.sel, e.segm, e.fd);
            end
            es = (since_rst < 4) ? 4'b0000 : 4'(1 << ((since_rst / 4 - 1) % 4));
            ef = (since_rst % 16 == 4);
            vectors++;
            if (sel !== es || frame_done !== ef) begin
                errors++;
                $display("FAIL scan_timing c=%0d: sel=%b fd=%b, expected sel=%b fd=%b",
                         since_rst, sel, frame_done, es, ef);
            end
        end
    endtask

    task automatic test_render();
        exp_t e;
        logic [13:0] eg;
        scroll_en = 1'b0;
        for (int i = 0; i < 4 + 48; i++) begin
            msg_we   = (i < 4);
            msg_addr = 3'(i);
            msg_char = (i < 4) ? sere[i] : 6'd0;
            step();
            e = exp_q.pop_front();
            vectors++;
            if (sel !== e.sel || segm !== e.segm || frame_done !== e.fd) begin
                errors++;
                $display("FAIL render: sel=%b segm=%b fd=%b, expected sel=%b segm=%b fd=%b",
                         sel, segm, frame_done, e.sel, e.segm, e.fd);
            end
            if (since_rst >= 40) begin
                eg = glyph(sere[(since_rst / 4 - 1) % 4]);
                vectors++;
                if (segm !== eg) begin
                    errors++;
                    $display("FAIL render_glyph c=%0d: segm=%b, expected %b", since_rst, segm, eg);
                end
            end
        end
        msg_we = 1'b0;
    endtask

    task automatic test_scroll();
        exp_t e;
        scroll_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            e = exp_q.pop_front();
            vectors++;
            if (sel !== e.sel || segm !== e.segm || frame_done !== e.fd) begin
                errors++;
                $display("FAIL scroll i=%0d off=%0d: sel=%b segm=%b fd=%b, expected sel=%b segm=%b fd=%b",
                         i, m_off, sel, segm, frame_done, e.sel, e.segm, e.fd);
            end
        end
        scroll_en = 1'b0;
    endtask

    task automatic test_blank();
        exp_t e;
        blank = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            if (i == 21) blank = 1'b0;
            step();
            e = exp_q.pop_front();
            vectors++;
            if (sel !== e.sel || segm !== e.segm || frame_done !== e.fd) begin
                errors++;
                $display("FAIL blank: sel=%b segm=%b fd=%b, expected sel=%b segm=%b fd=%b",
                         sel, segm, frame_done, e.sel, e.segm, e.fd);
            end
            if (i >= 4 && i <= 20) begin
                vectors++;
                if (segm !== c_SP || sel == 4'b0000) begin
                    errors++;
                    $display("FAIL blank_force i=%0d: sel=%b segm=%b, expected scanning sel and segm=0",
                             i, sel, segm);
                end
            end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        int   idx;
        bit   found = 1'b0;
        logic [13:0] old_g;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_div == 3 && m_dig == 1) begin
                found = 1'b1;
            end else begin
                step();
                e = exp_q.pop_front();
                vectors++;
                if (sel !== e.sel || segm !== e.segm || frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL collision_pre: sel=%b segm=%b, expected sel=%b segm=%b",
                             sel, segm, e.sel, e.segm);
                end
            end
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL collision_align: digit-2 tick not reached, got 0 expected 1");
        end
        idx      = (m_off + 2) % 8;
        old_g    = glyph(m_buf[idx]);
        msg_we   = 1'b1;
        msg_addr = 3'(idx);
        msg_char = 6'd1;
        step();
        msg_we   = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (sel !== 4'b0100 || segm !== old_g || segm !== e.segm) begin
            errors++;
            $display("FAIL collision_old: sel=%b segm=%b, expected sel=0100 segm=%b", sel, segm, old_g);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            e = exp_q.pop_front();
            vectors++;
            if (sel !== e.sel || segm !== e.segm || frame_done !== e.fd) begin
                errors++;
                $display("FAIL collision_post: sel=%b segm=%b, expected sel=%b segm=%b",
                         sel, segm, e.sel, e.segm);
            end
        end
        vectors++;
        if (sel !== 4'b0100 || segm !== c_A) begin
            errors++;
            $display("FAIL collision_new: sel=%b segm=%b, expected sel=0100 segm=%b", sel, segm, c_A);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            step();
            void'(exp_q.pop_front());
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (sel !== 4'b0000 || segm !== c_SP || frame_done !== 1'b0 || sel !== e.sel) begin
            errors++;
            $display("FAIL reset_mid: sel=%b segm=%b fd=%b, expected all zero", sel, segm, frame_done);
        end
        for (int i = 0; i < 24; i++) begin
            step();
            e = exp_q.pop_front();
            vectors++;
            if (sel !== e.sel || segm !== c_SP || frame_done !== e.fd) begin
                errors++;
                $display("FAIL reset_clear: sel=%b segm=%b fd=%b, expected sel=%b segm=%b fd=%b",
                         sel, segm, frame_done, e.sel, c_SP, e.fd);
            end
        end
    endtask

    task automatic test_bad_addr();
        exp2_t e;
        int    d;
        rst6 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst6 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            we6   = (k <= 6);
            addr6 = (k <= 4) ? 3'(k - 1) : 3'(k + 1);
            char6 = (k <= 4) ? sere[k - 1] : 6'd1;
            d     = (k / 4 - 1) % 4;
            if (k < 4) exp2_q.push_back({12'b0, c_SP, 1'b0});
            else       exp2_q.push_back({12'(1 << d), glyph(sere[d]), 1'(k % 16 == 4)});
            @(posedge clk);
            #1;
            e = exp2_q.pop_front();
            vectors++;
            if ({8'b0, sel6} !== e.sel || segm6 !== e.segm || fd6 !== e.fd) begin
                errors++;
                $display("FAIL bad_addr k=%0d: sel=%b segm=%b fd=%b, expected sel=%b segm=%b fd=%b",
                         k, sel6, segm6, fd6, e.sel[3:0], e.segm, e.fd);
            end
        end
        we6 = 1'b0;
    endtask

    task automatic test_fast();
        exp2_t e;
        rst12 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst12 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            exp2_q.push_back({12'(1 << ((k - 1) % 12)), c_SP, 1'((k - 1) % 12 == 0)});
            @(posedge clk);
            #1;
            e = exp2_q.pop_front();
            vectors++;
            if (sel12 !== e.sel || segm12 !== e.segm || fd12 !== e.fd) begin
                errors++;
                $display("FAIL fast_scan k=%0d: sel=%b segm=%b fd=%b, expected sel=%b segm=%b fd=%b",
                         k, sel12, segm12, fd12, e.sel, e.segm, e.fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_render();
        test_scroll();
        test_blank();
        test_collision();
        test_reset_mid();
        test_bad_addr();
        test_fast();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
